// File: rtl/decim_sequencer.sv
// Timing/enable sequencer for the PDM decimation chain (mic clock, stage strobes, wake/settle FSM).
// Optional output sample counter is enabled by defining DECIM_SAMPLE_CNT_EN.
module decim_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int CIC_R    = 16,
    parameter int HB1_R    = 4,
    parameter int HB2_R    = 3,
    parameter int MIC_WAKE = 64,
    parameter int SETTLE_N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        mic_clk,
    output logic        pdm_sample_en,
    output logic        cic_en,
    output logic        hb1_en,
    output logic        hb2_en,
    output logic        filt_clr,
    output logic        audio_valid,
    output logic [1:0]  state,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DIV_W    = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int CIC_W    = (CIC_R    > 1) ? $clog2(CIC_R)    : 1;
    localparam int HB1_W    = (HB1_R    > 1) ? $clog2(HB1_R)    : 1;
    localparam int HB2_W    = (HB2_R    > 1) ? $clog2(HB2_R)    : 1;
    localparam int WAKE_W   = (MIC_WAKE > 1) ? $clog2(MIC_WAKE) : 1;
    localparam int SETTLE_W = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;

    localparam logic [DIV_W-1:0]    DIV_MAX    = DIV_W'(CLK_DIV - 1);
    localparam logic [CIC_W-1:0]    CIC_MAX    = CIC_W'(CIC_R - 1);
    localparam logic [HB1_W-1:0]    HB1_MAX    = HB1_W'(HB1_R - 1);
    localparam logic [HB2_W-1:0]    HB2_MAX    = HB2_W'(HB2_R - 1);
    localparam logic [WAKE_W-1:0]   WAKE_MAX   = WAKE_W'(MIC_WAKE - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_N - 1);

    state_t              state_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [CIC_W-1:0]    cic_cnt_q;
    logic [HB1_W-1:0]    hb1_cnt_q;
    logic [HB2_W-1:0]    hb2_cnt_q;
    logic [WAKE_W-1:0]   wake_cnt_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                mic_clk_q;
    logic                pdm_en_q;
    logic                cic_en_q;
    logic                hb1_en_q;
    logic                hb2_en_q;
    logic                filt_clr_q;
    logic                audio_valid_q;

    logic div_wrap_d;
    logic rise_d;

    // rise_d marks the edge on which the registered mic_clk goes 0->1.
    assign div_wrap_d = (div_cnt_q == DIV_MAX);
    assign rise_d     = div_wrap_d && !mic_clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            cic_cnt_q     <= '0;
            hb1_cnt_q     <= '0;
            hb2_cnt_q     <= '0;
            wake_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            mic_clk_q     <= 1'b0;
            pdm_en_q      <= 1'b0;
            cic_en_q      <= 1'b0;
            hb1_en_q      <= 1'b0;
            hb2_en_q      <= 1'b0;
            filt_clr_q    <= 1'b0;
            audio_valid_q <= 1'b0;
        end else if (state_q == IDLE || !enable) begin
            // Idle or disable: everything cleared, in-flight strobes dropped.
            state_q       <= (state_q == IDLE && enable) ? WAKE : IDLE;
            filt_clr_q    <= (state_q == IDLE) && enable;
            div_cnt_q     <= '0;
            cic_cnt_q     <= '0;
            hb1_cnt_q     <= '0;
            hb2_cnt_q     <= '0;
            wake_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            mic_clk_q     <= 1'b0;
            pdm_en_q      <= 1'b0;
            cic_en_q      <= 1'b0;
            hb1_en_q      <= 1'b0;
            hb2_en_q      <= 1'b0;
            audio_valid_q <= 1'b0;
        end else begin
            filt_clr_q <= 1'b0;
            div_cnt_q  <= div_wrap_d ? '0 : div_cnt_q + DIV_W'(1);
            if (div_wrap_d) begin
                mic_clk_q <= ~mic_clk_q;
            end

            pdm_en_q <= rise_d && (state_q == SETTLE || state_q == RUN);

            if (pdm_en_q) begin
                cic_cnt_q <= (cic_cnt_q == CIC_MAX) ? '0 : cic_cnt_q + CIC_W'(1);
            end
            cic_en_q <= pdm_en_q && (cic_cnt_q == CIC_MAX);

            if (cic_en_q) begin
                hb1_cnt_q <= (hb1_cnt_q == HB1_MAX) ? '0 : hb1_cnt_q + HB1_W'(1);
            end
            hb1_en_q <= cic_en_q && (hb1_cnt_q == HB1_MAX);

            if (hb1_en_q) begin
                hb2_cnt_q <= (hb2_cnt_q == HB2_MAX) ? '0 : hb2_cnt_q + HB2_W'(1);
            end
            hb2_en_q <= hb1_en_q && (hb2_cnt_q == HB2_MAX);

            audio_valid_q <= hb2_en_q && (state_q == RUN);

            case (state_q)
                WAKE: begin
                    if (rise_d) begin
                        if (wake_cnt_q == WAKE_MAX) begin
                            wake_cnt_q <= '0;
                            state_q    <= SETTLE;
                        end else begin
                            wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (hb2_en_q) begin
                        if (settle_cnt_q == SETTLE_MAX) begin
                            settle_cnt_q <= '0;
                            state_q      <= RUN;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DECIM_SAMPLE_CNT_EN
    logic [15:0] sample_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
        end else if (state_q == IDLE && enable) begin
            sample_cnt_q <= '0;
        end else if (audio_valid_q) begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
        end
    end

    assign sample_cnt = sample_cnt_q;
`else
    assign sample_cnt = '0;
`endif

    assign mic_clk       = mic_clk_q;
    assign pdm_sample_en = pdm_en_q;
    assign cic_en        = cic_en_q;
    assign hb1_en        = hb1_en_q;
    assign hb2_en        = hb2_en_q;
    assign filt_clr      = filt_clr_q;
    assign audio_valid   = audio_valid_q;
    assign state         = state_q;

endmodule
